team_06_tremolo_lfo: RTL and testbench
======================================

Name: team_06_tremolo_lfo

Overview:
Parametrised tremolo stage. It amplitude-modulates a sampled audio stream with a selectable low-frequency oscillator (LFO): triangle, square, saw-up or saw-down. The LFO rate is programmable through a sample-count prescaler. The block sits in the effects chain between the sample source and the output mixer, clocked by clkdiv and qualified per sample by sample_valid.

Parameters:
DATA_W, 8, audio sample width (unsigned).
DEPTH_BITS, 4, LFO resolution; PEAK = 2**DEPTH_BITS (default 16); full gain = PEAK.
RATE_W, 8, width of the rate prescaler input.

Ports:
clkdiv  in  1  clock
rst  in  1  asynchronous, active-high reset
en  in  1  effect enable; 0 = bypass with LFO frozen
sample_valid  in  1  one-cycle strobe, audio_in valid
audio_in  in  DATA_W  unsigned input sample
rate  in  RATE_W  LFO steps once every rate+1 valid samples
mode  in  2  00 triangle, 01 square, 10 saw-up, 11 saw-down
lfo_sync  in  1  one-cycle strobe; phase restarts at 0
audio_out  out  DATA_W  registered modulated sample
out_valid  out  1  one-cycle strobe, audio_out updated
lfo_level  out  DEPTH_BITS+1  current gain L (0..PEAK), combinational from phase

Behaviour:
- Reset (async, rst=1): phase=0, prescaler=0, audio_out=0, out_valid=0. lfo_level then reads as the level for phase 0 in the current mode.
- phase register P: DEPTH_BITS+1 bits, range 0..2*PEAK-1, wraps 2*PEAK-1 -> 0. LFO period = 2*PEAK steps in every mode.
- Level L, combinational from P and mode:
  - Triangle: L = P when P<=PEAK, else 2*PEAK-P (sequence 0..PEAK..1).
  - Square: L = PEAK when P<PEAK, else 0.
  - Saw-up: L = P>>1 (range 0..PEAK-1).
  - Saw-down: L = PEAK-(P>>1) (range PEAK..1).
- Prescaler, on a clkdiv edge with sample_valid=1 and en=1:
  - if prescaler >= rate: prescaler <= 0 and P advances by 1;
  - else prescaler increments.
  - The >= compare makes a mid-run reduction of rate step on the next strobe instead of overrunning.
- lfo_sync=1 (any en): P<=0 and prescaler<=0 on that edge. Takes priority over a coincident step.
- Datapath, on each edge with sample_valid=1:
  - en=1: audio_out <= (audio_in * L) >> DEPTH_BITS, using a full-width DATA_W+DEPTH_BITS+1 product, then truncating.
  - en=0: audio_out <= audio_in (bypass).
  - L=PEAK returns audio_in exactly; no saturation is needed.
- The sample uses L from the pre-step phase. A step on the same edge affects the next sample.
- out_valid <= sample_valid every cycle, giving 1-cycle latency. audio_out holds between strobes.
- en=0: P and prescaler are held; the waveform resumes from the same point when en returns to 1.
- mode change: P is not reset. L is recomputed immediately and the next sample uses the new shape.
- sample_valid=0: no state changes except lfo_sync; out_valid=0.

Decomposition:
- Package team_06_fx_pkg:
  - typedef lfo_mode_t (enum: LFO_TRI, LFO_SQR, LFO_SAW_UP, LFO_SAW_DN);
  - localparam helpers for PEAK.
- One sub-module, team_06_lfo_core, contains the prescaler, phase counter, sync logic and level decode, and outputs L.
- The top contains the multiplier, shift, bypass mux and output registers.

Test Plan:
1. Reset: hold rst with activity on inputs -> audio_out=0, out_valid=0, lfo_level=0 (triangle); release -> first strobe gives out_valid pulse after exactly 1 cycle.
2. Triangle, rate=0, en=1, audio_in=200, strobe every 4 clocks:
   - lfo_level sequence 0,1..16,15..1,0 repeating;
   - audio_out=100 at L=8, 200 at L=16, 12 at L=1.
3. rate=3: L increments once per 4 strobes. Change rate 3->1 while prescaler=3 -> step on the next strobe, then every 2 strobes.
4. Square, rate=0, audio_in=255 -> 16 outputs of 255, then 16 outputs of 0. Saw-down from reset -> L=16,16,15,15..1,1, then 16.
5. en=0 mid-sweep at L=5, audio_in=0xC8 -> audio_out=0xC8 and L stays 5 over 10 strobes; en=1 -> the next step gives L=6.
6. lfo_sync asserted on the same edge as a step at P=20 -> P=0 (triangle L=0), prescaler=0. Sync with en=0 also clears P.

Source files
------------

// File: rtl/team_06_fx_pkg.sv
// Shared types and constants for the team_06 effects chain.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package team_06_fx_pkg;

    typedef enum logic [1:0] {
        LFO_TRI    = 2'b00,
        LFO_SQR    = 2'b01,
        LFO_SAW_UP = 2'b10,
        LFO_SAW_DN = 2'b11
    } lfo_mode_t;

    localparam int DEF_DEPTH_BITS = 4;

    // Full-scale gain for a given LFO resolution.
    function automatic int peak_of(input int depth_bits);
        return 1 << depth_bits;
    endfunction

    localparam int DEF_PEAK = peak_of(DEF_DEPTH_BITS);

endpackage

// File: rtl/team_06_lfo_core.sv
// LFO: sample-count prescaler, phase counter with sync restart, level decode.
// Latency: level is combinational from the phase register; phase steps on the strobe edge.
// Backpressure: none; advances only on sample_valid with en, holds otherwise.
module team_06_lfo_core
    import team_06_fx_pkg::*;
#(
    parameter int DEPTH_BITS = DEF_DEPTH_BITS,
    parameter int RATE_W     = 8
) (
    input  logic                  clkdiv,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  sample_valid,
    input  logic [RATE_W-1:0]     rate,
    input  logic [1:0]            mode,
    input  logic                  lfo_sync,
    output logic [DEPTH_BITS:0]   level
);

    localparam int PW   = DEPTH_BITS + 1;
    localparam int PEAK = peak_of(DEPTH_BITS);
    localparam logic [PW:0] PEAK_X = PEAK[PW:0];

    logic [PW-1:0]     phase;
    logic [RATE_W-1:0] presc;
    logic [PW:0]       p_ext;
    logic [PW:0]       lvl_x;
    lfo_mode_t         mode_e;

    // Sync wins over a coincident step; >= lets a lowered rate take effect at once.
    always_ff @(posedge clkdiv or posedge rst) begin
        if (rst) begin
            phase <= '0;
            presc <= '0;
        end else if (lfo_sync) begin
            phase <= '0;
            presc <= '0;
        end else if (sample_valid && en) begin
            if (presc >= rate) begin
                presc <= '0;
                phase <= phase + 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

    assign p_ext  = {1'b0, phase};
    assign mode_e = lfo_mode_t'(mode);

    // One extra bit so 2*PEAK is representable for the triangle fold.
    always_comb begin
        lvl_x = '0;
        case (mode_e)
            LFO_TRI:    lvl_x = (p_ext <= PEAK_X) ? p_ext : ((PEAK_X << 1) - p_ext);
            LFO_SQR:    lvl_x = (p_ext < PEAK_X) ? PEAK_X : '0;
            LFO_SAW_UP: lvl_x = p_ext >> 1;
            LFO_SAW_DN: lvl_x = PEAK_X - (p_ext >> 1);
            default:    lvl_x = '0;
        endcase
    end

    assign level = PW'(lvl_x);

endmodule

// File: rtl/team_06_tremolo_lfo.sv
// Tremolo: scales each valid sample by the LFO gain, or bypasses when disabled.
// Latency: 1 clkdiv cycle from sample_valid to out_valid.
// Backpressure: none; every strobe produces one output strobe.
module team_06_tremolo_lfo
    import team_06_fx_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int DEPTH_BITS = DEF_DEPTH_BITS,
    parameter int RATE_W     = 8
) (
    input  logic                  clkdiv,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  sample_valid,
    input  logic [DATA_W-1:0]     audio_in,
    input  logic [RATE_W-1:0]     rate,
    input  logic [1:0]            mode,
    input  logic                  lfo_sync,
    output logic [DATA_W-1:0]     audio_out,
    output logic                  out_valid,
    output logic [DEPTH_BITS:0]   lfo_level
);

    localparam int LW    = DEPTH_BITS + 1;
    localparam int PRODW = DATA_W + DEPTH_BITS + 1;

    logic [PRODW-1:0] product;

    team_06_lfo_core #(
        .DEPTH_BITS (DEPTH_BITS),
        .RATE_W     (RATE_W)
    ) u_lfo (
        .clkdiv       (clkdiv),
        .rst          (rst),
        .en           (en),
        .sample_valid (sample_valid),
        .rate         (rate),
        .mode         (mode),
        .lfo_sync     (lfo_sync),
        .level        (lfo_level)
    );

    // Gain of PEAK reproduces the input exactly, so the shifted product never overflows.
    assign product = {{(PRODW-DATA_W){1'b0}}, audio_in} * {{(PRODW-LW){1'b0}}, lfo_level};

    always_ff @(posedge clkdiv or posedge rst) begin
        if (rst) begin
            audio_out <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= sample_valid;
            if (sample_valid) begin
                audio_out <= en ? DATA_W'(product >> DEPTH_BITS) : audio_in;
            end
        end
    end

endmodule

// File: tb/tb_team_06_tremolo_lfo.sv
// Directed bench for team_06_tremolo_lfo with an expected-output queue and a phase model.
module tb_team_06_tremolo_lfo;

    logic       clkdiv = 1'b0;
    logic       rst;
    logic       en;
    logic       sample_valid;
    logic [7:0] audio_in;
    logic [7:0] rate;
    logic [1:0] mode;
    logic       lfo_sync;
    logic [7:0] audio_out;
    logic       out_valid;
    logic [4:0] lfo_level;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];
    int m_p   = 0;
    int m_pre = 0;
    int lvl, out;

    team_06_tremolo_lfo #(.DATA_W(8), .DEPTH_BITS(4), .RATE_W(8)) dut (
        .clkdiv       (clkdiv),
        .rst          (rst),
        .en           (en),
        .sample_valid (sample_valid),
        .audio_in     (audio_in),
        .rate         (rate),
        .mode         (mode),
        .lfo_sync     (lfo_sync),
        .audio_out    (audio_out),
        .out_valid    (out_valid),
        .lfo_level    (lfo_level)
    );

    always #5 clkdiv = ~clkdiv;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int model_level();
        case (mode)
            2'd0:    return (m_p <= 16) ? m_p : 32 - m_p;
            2'd1:    return (m_p < 16) ? 16 : 0;
            2'd2:    return m_p >> 1;
            default: return 16 - (m_p >> 1);
        endcase
    endfunction

    // One strobe, then three idle clocks; called at posedge+1.
    task automatic do_sample(input int a, input bit sync, output int lvl_o, output int out_o);
        int l_exp;
        audio_in     = 8'(a);
        sample_valid = 1'b1;
        lfo_sync     = sync;
        #1;
        l_exp = model_level();
        lvl_o = int'(lfo_level);
        check("level_pre_edge", lfo_level, l_exp);
        exp_q.push_back(en ? ((a * l_exp) >> 4) : a);
        if (sync) begin
            m_p = 0; m_pre = 0;
        end else if (en) begin
            if (m_pre >= int'(rate)) begin
                m_pre = 0; m_p = (m_p + 1) % 32;
            end else begin
                m_pre++;
            end
        end
        @(posedge clkdiv); #1;
        sample_valid = 1'b0;
        lfo_sync     = 1'b0;
        check("out_valid_pulse", out_valid, 1);
        if (exp_q.size() > 0) check("audio_out_scoreboard", audio_out, exp_q.pop_front());
        out_o = int'(audio_out);
        @(posedge clkdiv); #1;
        check("out_valid_low", out_valid, 0);
        repeat (2) @(posedge clkdiv);
        #1;
    endtask

    task automatic pulse_sync();
        lfo_sync = 1'b1;
        @(posedge clkdiv); #1;
        lfo_sync = 1'b0;
        m_p = 0; m_pre = 0;
        check("sync_no_valid", out_valid, 0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; sample_valid = 1'b0; lfo_sync = 1'b0;
        audio_in = 8'd0; rate = 8'd0; mode = 2'd0;

        // 1. reset held with input activity
        repeat (4) begin
            @(posedge clkdiv); #1;
            sample_valid = ~sample_valid;
            audio_in     = 8'($urandom);
            lfo_sync     = 1'($urandom);
        end
        check("reset_audio_out", audio_out, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_level_tri", lfo_level, 0);
        sample_valid = 1'b0; lfo_sync = 1'b0; audio_in = 8'd0;
        rst = 1'b0; m_p = 0; m_pre = 0;
        @(posedge clkdiv); #1;

        // 2. triangle sweep, rate 0
        for (int i = 0; i <= 32; i++) begin
            do_sample(200, 1'b0, lvl, out);
            if (i == 8)  check("tri_out_l8", out, 100);
            if (i == 16) check("tri_out_l16", out, 200);
            if (i == 31) check("tri_out_l1", out, 12);
            if (i == 32) check("tri_wrap_l0", lvl, 0);
        end

        // 3. prescaler and mid-run rate reduction
        rate = 8'd3;
        pulse_sync();
        for (int i = 0; i < 7; i++) begin
            do_sample(200, 1'b0, lvl, out);
            if (i == 3) check("rate3_step_after4", lfo_level, 1);
        end
        rate = 8'd1;
        do_sample(200, 1'b0, lvl, out);
        check("rate_drop_immediate_step", lfo_level, 2);
        do_sample(200, 1'b0, lvl, out);
        check("rate1_hold", lfo_level, 2);
        do_sample(200, 1'b0, lvl, out);
        check("rate1_step", lfo_level, 3);

        // 4. square, then saw-down from reset
        rate = 8'd0; mode = 2'd1;
        pulse_sync();
        for (int i = 0; i < 32; i++) begin
            do_sample(255, 1'b0, lvl, out);
            if (i == 0 || i == 15)  check("sqr_high", out, 255);
            if (i == 16 || i == 31) check("sqr_low", out, 0);
        end
        rst = 1'b1; mode = 2'd3;
        @(posedge clkdiv); #1;
        check("reset2_audio_out", audio_out, 0);
        check("reset2_level_sawdn", lfo_level, 16);
        rst = 1'b0; m_p = 0; m_pre = 0;
        @(posedge clkdiv); #1;
        for (int i = 0; i <= 32; i++) begin
            do_sample(100, 1'b0, lvl, out);
            if (i == 0 || i == 1) check("sawdn_top", lvl, 16);
            if (i == 2)  check("sawdn_15", lvl, 15);
            if (i == 31) check("sawdn_bottom", lvl, 1);
            if (i == 32) check("sawdn_wrap", lvl, 16);
        end

        // 5. bypass freezes the LFO
        mode = 2'd0;
        pulse_sync();
        repeat (5) do_sample(200, 1'b0, lvl, out);
        check("pre_bypass_level", lfo_level, 5);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            do_sample(8'hC8, 1'b0, lvl, out);
            check("bypass_out", out, 200);
            check("bypass_level_frozen", lvl, 5);
        end
        en = 1'b1;
        do_sample(200, 1'b0, lvl, out);
        check("resume_out_l5", out, 62);
        check("resume_step_l6", lfo_level, 6);

        // 6. sync against a coincident step, prescaler clear, sync while disabled
        pulse_sync();
        repeat (20) do_sample(200, 1'b0, lvl, out);
        check("tri_p20_level", lfo_level, 12);
        do_sample(200, 1'b1, lvl, out);
        check("sync_step_out", out, 150);
        check("sync_step_level0", lfo_level, 0);
        rate = 8'd3;
        repeat (2) do_sample(200, 1'b0, lvl, out);
        do_sample(200, 1'b1, lvl, out);
        repeat (3) do_sample(200, 1'b0, lvl, out);
        check("sync_cleared_presc_hold", lfo_level, 0);
        do_sample(200, 1'b0, lvl, out);
        check("sync_cleared_presc_step", lfo_level, 1);
        rate = 8'd0;
        repeat (3) do_sample(200, 1'b0, lvl, out);
        en = 1'b0;
        pulse_sync();
        check("sync_en0_level", lfo_level, 0);
        en = 1'b1;
        do_sample(200, 1'b0, lvl, out);
        check("sync_en0_resume", lfo_level, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
